// File: rtl/blackjack_deal_ctrl.sv
// Blackjack round controller: deals from an external shuffled deck store, runs the
// player and dealer turns and resolves the hand. Soft-ace scoring: BLACKJACK_SOFT_ACE_EN.
module blackjack_deal_ctrl #(
    parameter int DECK_SIZE    = 52,
    parameter int DEALER_STAND = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       new_deck,
    input  logic       hit,
    input  logic       stand,
    output logic [5:0] card_addr,
    input  logic [5:0] card_data,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic       player_turn,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       deck_err
);

    typedef enum logic [2:0] {
        IDLE,
        DEAL,
        PLAYER,
        PFETCH,
        DEALER,
        RESOLVE,
        DONE
    } state_t;

    state_t     state, state_n;
    logic       phase, phase_n;
    logic [5:0] ptr, ptr_n;
    logic [1:0] deal_cnt, deal_cnt_n;
    logic [4:0] p_hard, d_hard;
    logic [1:0] result_n;
    logic       deck_err_n;
    logic       clr_hands, p_load, d_load;

    logic [3:0] card_mod;
    logic [4:0] card_val;
    logic [4:0] p_sum, d_sum, p_sum_rep;
    logic       deck_empty;

    assign card_mod   = 4'(card_data % 6'd13);
    assign card_val   = (card_mod >= 4'd9) ? 5'd10 : {1'b0, card_mod} + 5'd1;
    assign p_sum      = p_hard + card_val;
    assign d_sum      = d_hard + card_val;
    assign deck_empty = (ptr == 6'(DECK_SIZE));

`ifdef BLACKJACK_SOFT_ACE_EN
    logic p_ace, d_ace, card_ace;

    assign card_ace = (card_mod == 4'd0);

    // One ace per hand may count 11 whenever that keeps the hand at or below 21.
    function automatic logic [4:0] score(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ace <= 1'b0;
            d_ace <= 1'b0;
        end else if (clr_hands) begin
            p_ace <= 1'b0;
            d_ace <= 1'b0;
        end else begin
            if (p_load && card_ace) p_ace <= 1'b1;
            if (d_load && card_ace) d_ace <= 1'b1;
        end
    end

    assign player_total = score(p_hard, p_ace);
    assign dealer_total = score(d_hard, d_ace);
    assign p_sum_rep    = score(p_sum, p_ace | card_ace);
`else
    assign player_total = p_hard;
    assign dealer_total = d_hard;
    assign p_sum_rep    = p_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= 1'b0;
            ptr      <= '0;
            deal_cnt <= '0;
            p_hard   <= '0;
            d_hard   <= '0;
            result   <= 2'b00;
            deck_err <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            ptr      <= ptr_n;
            deal_cnt <= deal_cnt_n;
            result   <= result_n;
            deck_err <= deck_err_n;
            if (clr_hands) begin
                p_hard <= '0;
                d_hard <= '0;
            end else begin
                if (p_load) p_hard <= p_sum;
                if (d_load) d_hard <= d_sum;
            end
        end
    end

    // Every fetch is phase 0 (address out) then phase 1 (data back, latch and advance).
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        ptr_n      = ptr;
        deal_cnt_n = deal_cnt;
        result_n   = result;
        deck_err_n = deck_err;
        clr_hands  = 1'b0;
        p_load     = 1'b0;
        d_load     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (new_deck) ptr_n = '0;
                if (start) begin
                    clr_hands  = 1'b1;
                    result_n   = 2'b00;
                    deck_err_n = 1'b0;
                    deal_cnt_n = '0;
                    phase_n    = 1'b0;
                    state_n    = DEAL;
                end
            end
            DEAL: begin
                if (!phase) begin
                    if (deck_empty) begin
                        deck_err_n = 1'b1;
                        result_n   = 2'b00;
                        state_n    = DONE;
                    end else begin
                        phase_n = 1'b1;
                    end
                end else begin
                    phase_n    = 1'b0;
                    ptr_n      = ptr + 6'd1;
                    deal_cnt_n = deal_cnt + 2'd1;
                    p_load     = ~deal_cnt[1];
                    d_load     = deal_cnt[1];
                    if (deal_cnt == 2'd3) state_n = PLAYER;
                end
            end
            PLAYER: begin
                if (stand) state_n = DEALER;
                else if (hit) state_n = PFETCH;
            end
            PFETCH: begin
                if (!phase) begin
                    if (deck_empty) begin
                        deck_err_n = 1'b1;
                        result_n   = 2'b00;
                        state_n    = DONE;
                    end else begin
                        phase_n = 1'b1;
                    end
                end else begin
                    phase_n = 1'b0;
                    ptr_n   = ptr + 6'd1;
                    p_load  = 1'b1;
                    state_n = (p_sum_rep > 5'd21) ? RESOLVE : PLAYER;
                end
            end
            DEALER: begin
                if (!phase) begin
                    if (dealer_total >= 5'(DEALER_STAND)) begin
                        state_n = RESOLVE;
                    end else if (deck_empty) begin
                        deck_err_n = 1'b1;
                        result_n   = 2'b00;
                        state_n    = DONE;
                    end else begin
                        phase_n = 1'b1;
                    end
                end else begin
                    phase_n = 1'b0;
                    ptr_n   = ptr + 6'd1;
                    d_load  = 1'b1;
                end
            end
            RESOLVE: begin
                if (player_total > 5'd21)            result_n = 2'b10;
                else if (dealer_total > 5'd21)       result_n = 2'b01;
                else if (player_total > dealer_total) result_n = 2'b01;
                else if (dealer_total > player_total) result_n = 2'b10;
                else                                 result_n = 2'b11;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign card_addr   = ptr;
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign player_turn = (state == PLAYER);

endmodule

// File: tb/tb_blackjack_deal_ctrl.sv
// Bench for blackjack_deal_ctrl: a round-level timing model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_blackjack_deal_ctrl;

    localparam int DECK_SIZE    = 52;
    localparam int DEALER_STAND = 16;
    localparam int BUDGET       = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, new_deck = 1'b0, hit = 1'b0, stand = 1'b0;
    logic [5:0] card_addr;
    logic [5:0] card_data = 6'd0;
    logic [4:0] player_total, dealer_total;
    logic       player_turn, busy, done, deck_err;
    logic [1:0] result;

    logic [5:0] deck [0:63];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         check_en = 1'b0;

    // Model of the round: expected visible state after each clock edge
    int  m_ptr, m_ph, m_dh, m_res;
    bit  m_pa, m_da, m_err, m_busy, m_done, m_turn;

    blackjack_deal_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .new_deck(new_deck),
        .hit(hit), .stand(stand), .card_addr(card_addr), .card_data(card_data),
        .player_total(player_total), .dealer_total(dealer_total),
        .player_turn(player_turn), .busy(busy), .done(done),
        .result(result), .deck_err(deck_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) card_data <= deck[card_addr];

    function automatic int cardValue(input logic [5:0] id);
        int v;
        v = int'(id) % 13 + 1;
        return (v > 10) ? 10 : v;
    endfunction

    function automatic int rep(input int hard, input bit ace);
`ifdef BLACKJACK_SOFT_ACE_EN
        if (ace && hard + 10 <= 21) return hard + 10;
`endif
        return hard;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic mClear();
        m_ptr = 0; m_ph = 0; m_dh = 0; m_res = 0;
        m_pa = 0; m_da = 0; m_err = 0; m_busy = 0; m_done = 0; m_turn = 0;
    endtask

    task automatic mStep(output bit ok);
        @(posedge clk or negedge rst_n);
        ok = rst_n;
        if (!ok) mClear();
    endtask

    task automatic mEndRound();
        m_busy = 0; m_turn = 0; m_done = 1;
    endtask

    task automatic mDraw(input bit to_player, output bit ok, output bit err);
        int v;
        err = 0;
        mStep(ok);
        if (!ok) return;
        if (m_ptr == DECK_SIZE) begin
            m_err = 1; m_res = 0; err = 1;
            mEndRound();
            return;
        end
        mStep(ok);
        if (!ok) return;
        v = cardValue(deck[m_ptr]);
        m_ptr++;
        if (to_player) begin m_ph += v; if (v == 1) m_pa = 1; end
        else begin m_dh += v; if (v == 1) m_da = 1; end
    endtask

    task automatic mResolve(output bit ok);
        int p, d;
        mStep(ok);
        if (!ok) return;
        p = rep(m_ph, m_pa);
        d = rep(m_dh, m_da);
        if (p > 21) m_res = 2;
        else if (d > 21) m_res = 1;
        else if (p > d) m_res = 1;
        else if (d > p) m_res = 2;
        else m_res = 3;
        mEndRound();
    endtask

    task automatic mRound();
        bit ok, err;
        m_ph = 0; m_dh = 0; m_pa = 0; m_da = 0; m_res = 0; m_err = 0;
        m_busy = 1; m_done = 0; m_turn = 0;
        for (int i = 0; i < 4; i++) begin
            mDraw(i < 2, ok, err);
            if (!ok || err) return;
        end
        forever begin
            m_turn = 1;
            mStep(ok);
            if (!ok) return;
            if (stand) begin
                m_turn = 0;
                break;
            end
            if (hit) begin
                m_turn = 0;
                mDraw(1, ok, err);
                if (!ok || err) return;
                if (rep(m_ph, m_pa) > 21) begin
                    mResolve(ok);
                    return;
                end
            end
        end
        while (rep(m_dh, m_da) < DEALER_STAND) begin
            mDraw(0, ok, err);
            if (!ok || err) return;
        end
        mStep(ok);
        if (!ok) return;
        mResolve(ok);
    endtask

    initial begin
        bit ok;
        mClear();
        forever begin
            mStep(ok);
            if (ok) begin
                if (new_deck) m_ptr = 0;
                if (start) mRound();
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("card_addr", card_addr, m_ptr);
            checkOutput("player_total", player_total, rep(m_ph, m_pa));
            checkOutput("dealer_total", dealer_total, rep(m_dh, m_da));
            checkOutput("player_turn", player_turn, m_turn);
            checkOutput("busy", busy, m_busy);
            checkOutput("done", done, m_done);
            checkOutput("result", result, m_res);
            checkOutput("deck_err", deck_err, m_err);
        end
    end

    task automatic applyStimulus(input bit s, input bit nd, input bit h, input bit st);
        @(negedge clk);
        start = s; new_deck = nd; hit = h; stand = st;
        @(negedge clk);
        start = 0; new_deck = 0; hit = 0; stand = 0;
    endtask

    task automatic waitFor(input string what, input bit want_turn, output int cycles);
        cycles = 0;
        while ((want_turn ? player_turn : done) !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= BUDGET) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL timeout waiting for %s: got no event in %0d cycles, expected one", what, BUDGET);
        end
    endtask

    task automatic loadDeck(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                            input logic [5:0] d, input logic [5:0] e);
        deck[0] = a; deck[1] = b; deck[2] = c; deck[3] = d; deck[4] = e;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_addr"}, card_addr, 0);
        checkOutput({tag, "_ptotal"}, player_total, 0);
        checkOutput({tag, "_dtotal"}, dealer_total, 0);
        checkOutput({tag, "_turn"}, player_turn, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_result"}, result, 0);
        checkOutput({tag, "_err"}, deck_err, 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) deck[i] = 6'd9;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        checkIdleOutputs("reset");

        // Dealer draws from 11 to 21 and beats the player's 18
        loadDeck(6'd9, 6'd7, 6'd4, 6'd5, 6'd12);
        applyStimulus(1, 1, 0, 0);
        waitFor("deal", 1, cyc);
        checkOutput("deal_latency", cyc, 8);
        checkOutput("r1_ptotal", player_total, 18);
        checkOutput("r1_dtotal", dealer_total, 11);
        applyStimulus(0, 0, 0, 1);
        waitFor("r1_done", 0, cyc);
        checkOutput("r1_dfinal", dealer_total, 21);
        checkOutput("r1_result", result, 2);
        checkOutput("r1_ptr", card_addr, 5);

        // Player busts on a hit: dealer keeps its dealt 10
        loadDeck(6'd9, 6'd9, 6'd5, 6'd3, 6'd8);
        applyStimulus(1, 1, 0, 0);
        waitFor("r2_turn", 1, cyc);
        applyStimulus(0, 0, 1, 0);
        waitFor("r2_done", 0, cyc);
        checkOutput("r2_ptotal", player_total, 29);
        checkOutput("r2_dtotal", dealer_total, 10);
        checkOutput("r2_result", result, 2);
        checkOutput("r2_ptr", card_addr, 5);

        // Push at 20; inputs during DEAL are ignored and hit+stand means stand
        loadDeck(6'd9, 6'd12, 6'd9, 6'd11, 6'd0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1);
        waitFor("r3_turn", 1, cyc);
        applyStimulus(0, 0, 1, 1);
        waitFor("r3_done", 0, cyc);
        checkOutput("r3_ptotal", player_total, 20);
        checkOutput("r3_dtotal", dealer_total, 20);
        checkOutput("r3_result", result, 3);
        checkOutput("r3_ptr", card_addr, 4);

        // Ten 5-card bust rounds bring the pointer to 50, then the deck runs dry
        for (int i = 0; i < 64; i++) deck[i] = 6'd9;
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1, (r == 0), 0, 0);
            waitFor("burn_turn", 1, cyc);
            applyStimulus(0, 0, 1, 0);
            waitFor("burn_done", 0, cyc);
        end
        checkOutput("burn_ptr", card_addr, 50);
        applyStimulus(1, 0, 0, 0);
        waitFor("empty_done", 0, cyc);
        checkOutput("empty_err", deck_err, 1);
        checkOutput("empty_result", result, 0);
        checkOutput("empty_done", done, 1);
        checkOutput("empty_ptr", card_addr, 52);
        checkOutput("empty_ptotal", player_total, 20);
        applyStimulus(1, 1, 0, 0);
        waitFor("refill_turn", 1, cyc);
        checkOutput("refill_ptr", card_addr, 4);
        checkOutput("refill_err", deck_err, 0);
        applyStimulus(0, 0, 0, 1);
        waitFor("refill_done", 0, cyc);
        checkOutput("refill_result", result, 3);

        // Asynchronous reset while the dealer is playing
        loadDeck(6'd9, 6'd7, 6'd4, 6'd5, 6'd12);
        applyStimulus(1, 1, 0, 0);
        waitFor("r5_turn", 1, cyc);
        applyStimulus(0, 0, 0, 1);
        checkOutput("r5_in_dealer", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkIdleOutputs("midreset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Ace plus ten: soft 21 with the soft-ace build, 11 otherwise
        loadDeck(6'd0, 6'd9, 6'd9, 6'd9, 6'd9);
        applyStimulus(1, 0, 0, 0);
        waitFor("ace_turn", 1, cyc);
`ifdef BLACKJACK_SOFT_ACE_EN
        checkOutput("ace_ptotal", player_total, 21);
`else
        checkOutput("ace_ptotal", player_total, 11);
`endif
        applyStimulus(0, 0, 0, 1);
        waitFor("ace_done", 0, cyc);
`ifdef BLACKJACK_SOFT_ACE_EN
        checkOutput("ace_result", result, 1);
`else
        checkOutput("ace_result", result, 2);
`endif

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] run complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
